// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared constants and types for the accumulator multiply unit.
//             Holds the default operand and accumulator-address widths and
//             the multiplier sequencing state type.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int ACC_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/shift_add_core.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_core
//  Purpose  : Shift-add multiply datapath. It holds the multiplicand,
//             multiplier, partial product and step counter. One partial
//             product is added per step, so a full multiply takes exactly
//             DATA_W steps.
//  Ports    : CLK, RST   clock and synchronous active-high reset
//             load       capture mcand/mplier/neg, clear product and count
//             step       perform one shift-add iteration
//             mcand      multiplicand (magnitude)
//             mplier     multiplier (magnitude)
//             neg        negate the result on the final step
//             prod       2*DATA_W product register
//             last       current step is the final one (count == DATA_W-1)
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_core #(
    parameter int DATA_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     mcand,
    input  logic [DATA_W-1:0]     mplier,
    input  logic                  neg,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  last
);

    // One spare bit so the counter can reach DATA_W without wrapping.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_prod;
    logic [CNT_W-1:0]    r_count;
    logic                r_neg;

    logic [2*DATA_W-1:0] w_mcand_ext;
    logic [2*DATA_W-1:0] w_addend;
    logic [2*DATA_W-1:0] w_sum;

    always_comb begin
        w_mcand_ext = {{DATA_W{1'b0}}, r_mcand};
        w_addend    = r_mplier[0] ? (w_mcand_ext << r_count) : '0;
        w_sum       = r_prod + w_addend;
    end

    assign last = (r_count == CNT_W'(DATA_W - 1));
    assign prod = r_prod;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
        end else if (load) begin
            r_mcand  <= mcand;
            r_mplier <= mplier;
            r_prod   <= '0;
            r_count  <= '0;
            r_neg    <= neg;
        end else if (step) begin
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            // Sign correction is folded into the final accumulate so the
            // signed path costs no extra cycle.
            r_prod   <= (last && r_neg) ? -w_sum : w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mul_unit
//  Purpose  : Multi-cycle DATA_W x DATA_W shift-add multiplier that writes
//             its 2*DATA_W product back to the accumulator file as two
//             byte writes: low half to dstLo, then high half to dstHi.
//             Sequence: IDLE -> MUL (DATA_W cycles) -> WR_LO -> WR_HI.
//  Ports    : CLK, RST   clock and synchronous active-high reset
//             start      request, sampled with operands when not busy
//             isSigned   (ACC_MUL_SIGNED_EN only) two's complement operands
//             opA, opB   multiplicand / multiplier
//             dstLo/Hi   accumulator addresses for the low/high product
//             busy       operation in progress
//             done       one-cycle pulse alongside the high write
//             isWrite, writeReg, writeData  accumulator write port
//  Config   : define ACC_MUL_SIGNED_EN to add the isSigned port and signed
//             multiplication; otherwise the multiply is always unsigned.
//  Revision : 1.0  initial release
// ============================================================================
module acc_mul_unit #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int ACC_ADDR_W = cpu_pkg::ACC_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
`ifdef ACC_MUL_SIGNED_EN
    input  logic                  isSigned,
`endif
    input  logic [DATA_W-1:0]     opA,
    input  logic [DATA_W-1:0]     opB,
    input  logic [ACC_ADDR_W-1:0] dstLo,
    input  logic [ACC_ADDR_W-1:0] dstHi,
    output logic                  busy,
    output logic                  done,
    output logic                  isWrite,
    output logic [ACC_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData
);

    import cpu_pkg::*;

    mul_state_t            r_state;
    mul_state_t            w_state_next;

    logic [ACC_ADDR_W-1:0] r_dst_lo;
    logic [ACC_ADDR_W-1:0] r_dst_hi;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_is_write;
    logic [ACC_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;

    logic                  w_accept;
    logic                  w_step;
    logic                  w_last;
    logic [DATA_W-1:0]     w_mcand;
    logic [DATA_W-1:0]     w_mplier;
    logic                  w_neg;
    logic [2*DATA_W-1:0]   w_prod;

    assign w_accept = (r_state == IDLE) && start;
    assign w_step   = (r_state == MUL);

`ifdef ACC_MUL_SIGNED_EN
    // Signed operands are reduced to magnitudes at accept; the most negative
    // value maps to 2^(DATA_W-1), which still fits as an unsigned magnitude.
    always_comb begin
        w_mcand  = (isSigned && opA[DATA_W-1]) ? -opA : opA;
        w_mplier = (isSigned && opB[DATA_W-1]) ? -opB : opB;
        w_neg    = isSigned && (opA[DATA_W-1] ^ opB[DATA_W-1]);
    end
`else
    always_comb begin
        w_mcand  = opA;
        w_mplier = opB;
        w_neg    = 1'b0;
    end
`endif

    shift_add_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .CLK    (CLK),
        .RST    (RST),
        .load   (w_accept),
        .step   (w_step),
        .mcand  (w_mcand),
        .mplier (w_mplier),
        .neg    (w_neg),
        .prod   (w_prod),
        .last   (w_last)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = MUL;
            MUL:     if (w_last) w_state_next = WR_LO;
            WR_LO:   w_state_next = WR_HI;
            WR_HI:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Destination capture and registered outputs. The write registers are
    // loaded while the sequencer sits in WR_LO / WR_HI, so each write
    // appears one edge after the state is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dst_lo     <= '0;
            r_dst_hi     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_is_write   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_is_write <= 1'b0;
            r_done     <= 1'b0;

            if (w_accept) begin
                r_dst_lo <= dstLo;
                r_dst_hi <= dstHi;
                r_busy   <= 1'b1;
            end

            case (r_state)
                WR_LO: begin
                    r_is_write   <= 1'b1;
                    r_write_reg  <= r_dst_lo;
                    r_write_data <= w_prod[DATA_W-1:0];
                end
                WR_HI: begin
                    r_is_write   <= 1'b1;
                    r_write_reg  <= r_dst_hi;
                    r_write_data <= w_prod[2*DATA_W-1:DATA_W];
                    r_done       <= 1'b1;
                    // Dropping busy here lets a new start be taken in the
                    // very next cycle.
                    r_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign isWrite   = r_is_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_acc_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_mul_unit
//  Purpose  : Self-checking bench for acc_mul_unit. Directed and randomized
//             multiplies are compared against plain integer arithmetic and a
//             model accumulator file fed from the DUT write port.
//  Config   : ACC_MUL_SIGNED_EN adds the signed-operand steps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_mul_unit;

    localparam int c_DATA_W  = 8;
    localparam int c_ADDR_W  = 3;
    localparam int c_LAT_LO  = c_DATA_W + 1;
    localparam int c_LAT_HI  = c_DATA_W + 2;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 start = 1'b0;
    logic                 isSigned = 1'b0;
    logic [c_DATA_W-1:0]  opA = '0;
    logic [c_DATA_W-1:0]  opB = '0;
    logic [c_ADDR_W-1:0]  dstLo = '0;
    logic [c_ADDR_W-1:0]  dstHi = '0;
    logic                 busy;
    logic                 done;
    logic                 isWrite;
    logic [c_ADDR_W-1:0]  writeReg;
    logic [c_DATA_W-1:0]  writeData;

    int checks = 0;
    int errors = 0;

    // Model accumulator file: captures writes at the edge, like the real file.
    logic [c_DATA_W-1:0] acc [8];
    int nwrites = 0;

    always #5 CLK = ~CLK;

    acc_mul_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
`ifdef ACC_MUL_SIGNED_EN
        .isSigned  (isSigned),
`endif
        .opA       (opA),
        .opB       (opB),
        .dstLo     (dstLo),
        .dstHi     (dstHi),
        .busy      (busy),
        .done      (done),
        .isWrite   (isWrite),
        .writeReg  (writeReg),
        .writeData (writeData)
    );

    always @(posedge CLK) begin
        if (isWrite === 1'b1) begin
            acc[writeReg] = writeData;
            nwrites++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int x;
        int y;
        x = sgn ? int'($signed(a)) : int'(a);
        y = sgn ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    // Issue one multiply and follow it cycle by cycle. Edge 0 is the accept
    // edge; samples are taken on the following negedge. With inject set, a
    // second start with different operands is pulsed during cycle 4.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] lo, input logic [2:0] hi,
                          input bit sgn, input bit inject);
        logic [15:0] exp;
        int busy_cycles;
        int w0;
        exp = ref_mul(a, b, sgn);
        w0  = nwrites;
        busy_cycles = 0;
        opA = a; opB = b; dstLo = lo; dstHi = hi; isSigned = sgn; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        for (int n = 1; n <= c_LAT_HI + 1; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (busy === 1'b1) busy_cycles++;
            if (inject && n == 4) begin
                opA = ~a; opB = b + 8'd1; dstLo = ~lo; dstHi = ~hi; start = 1'b1;
            end
            if (inject && n == 5) start = 1'b0;
            if (n < c_LAT_LO) begin
                check("idle_write_during_mul", isWrite, 0);
            end else if (n == c_LAT_LO) begin
                check("lo_isWrite", isWrite, 1);
                check("lo_reg", writeReg, lo);
                check("lo_data", writeData, exp[7:0]);
                check("lo_done", done, 0);
            end else if (n == c_LAT_HI) begin
                check("hi_isWrite", isWrite, 1);
                check("hi_reg", writeReg, hi);
                check("hi_data", writeData, exp[15:8]);
                check("hi_done", done, 1);
            end else begin
                check("post_isWrite", isWrite, 0);
                check("post_done", done, 0);
            end
        end
        check("busy_cycles", busy_cycles, 10);
        check("write_count", nwrites - w0, 2);
        check("acc_hi_final", acc[hi], exp[15:8]);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int w0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_isWrite", isWrite, 0);
        check("rst_writeReg", writeReg, 0);
        check("rst_writeData", writeData, 0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: 13*11 -> 0x008F
        run_op(8'd13, 8'd11, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t1_acc1", acc[1], 8'h8F);

        // 2: 255*255 -> 0xFE01, back-to-back with the previous op
        run_op(8'd255, 8'd255, 3'd3, 3'd5, 1'b0, 1'b0);
        check("t2_acc3", acc[3], 8'h01);

        // 3: second start ignored while busy
        run_op(8'd21, 8'd6, 3'd6, 3'd7, 1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        check("t3_busy_after", busy, 0);

        // 4: reset during cycle 5 of 7*9
        w0 = nwrites;
        opA = 8'd7; opB = 8'd9; dstLo = 3'd0; dstHi = 3'd1; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t4_busy_after_rst", busy, 0);
        for (int n = 0; n < 12; n++) begin
            @(negedge CLK);
            check("t4_no_write", isWrite, 0);
        end
        check("t4_write_count", nwrites - w0, 0);
        run_op(8'd3, 8'd4, 3'd0, 3'd1, 1'b0, 1'b0);
        check("t4_acc0", acc[0], 8'h0C);

        // 5: same destination for both halves
        run_op(8'd200, 8'd3, 3'd4, 3'd4, 1'b0, 1'b0);
        check("t5_acc4", acc[4], 8'h02);

        // Zero operands still take the full latency
        run_op(8'd0, 8'd0, 3'd2, 3'd3, 1'b0, 1'b0);
        run_op(8'd0, 8'd77, 3'd2, 3'd3, 1'b0, 1'b0);

        // 6: unsigned view of -3*5 operands
        run_op(8'hFD, 8'h05, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t6_unsigned_lo", acc[1], 8'hF1);
        check("t6_unsigned_hi", acc[2], 8'h04);

`ifdef ACC_MUL_SIGNED_EN
        run_op(8'hFD, 8'h05, 3'd1, 3'd2, 1'b1, 1'b0);
        check("t6_signed_lo", acc[1], 8'hF1);
        check("t6_signed_hi", acc[2], 8'hFF);
        run_op(8'h80, 8'h80, 3'd3, 3'd4, 1'b1, 1'b0);
        check("s_min_lo", acc[3], 8'h00);
        check("s_min_hi", acc[4], 8'h40);
        run_op(8'h80, 8'h7F, 3'd3, 3'd4, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0);
`endif

        // Randomized operands and destinations
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
`ifdef ACC_MUL_SIGNED_EN
            run_op(ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            run_op(ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'b0, 1'($urandom_range(0, 1)));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
